// File: rtl/rv32i_types.sv
// Shared RV32I core types used across the fetch and decode stages.
package rv32i_types;

    typedef enum logic {
        no_take = 1'b0,
        take    = 1'b1
    } prediction_choice;

endpackage

// File: rtl/local_bht_predictor_if.sv
// Lookup and training bus between the fetch stage and the branch history table.
interface local_bht_predictor_if
    import rv32i_types::*;
#(
    parameter int ENTRIES = 4,
    parameter int PC_W    = 32
);
    logic [PC_W-1:0]            lookup_pc;
    prediction_choice           prediction;
    logic                       pred_hit;
    logic                       upd_valid;
    logic [PC_W-1:0]            upd_pc;
    logic                       upd_taken;
    logic                       invalidate;
    logic [$clog2(ENTRIES):0]   occupancy;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, invalidate,
        input  prediction, pred_hit, occupancy
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, invalidate,
        output prediction, pred_hit, occupancy
    );
endinterface

// File: rtl/local_bht_predictor_sat_counter.sv
// Per-entry saturating up/down counter; resets to weakly-not-taken.
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [CTR_W-1:0] init_val,
    input  logic             inc_en,
    input  logic             dir,
    output logic [CTR_W-1:0] ctr
);
    localparam logic [CTR_W-1:0] WNT     = CTR_W'((2 ** (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    // Load on allocation, otherwise step towards the resolved direction without wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctr <= WNT;
        end else if (init) begin
            ctr <= init_val;
        end else if (inc_en) begin
            if (dir && ctr != CTR_MAX) begin
                ctr <= ctr + CTR_W'(1);
            end else if (!dir && ctr != '0) begin
                ctr <= ctr - CTR_W'(1);
            end
        end
    end
endmodule

// File: rtl/local_bht_predictor.sv
// Fully associative local branch history table: combinational lookup,
// single-port training with lowest-free-first then round-robin allocation.
module local_bht_predictor
    import rv32i_types::*;
#(
    parameter int ENTRIES = 4,
    parameter int CTR_W   = 2,
    parameter int PC_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    local_bht_predictor_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OCC_W = IDX_W + 1;
    localparam logic [CTR_W-1:0] WNT = CTR_W'((2 ** (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] WT  = CTR_W'(2 ** (CTR_W - 1));

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [PC_W-1:0]    tag_q [ENTRIES];
    logic [CTR_W-1:0]   ctr   [ENTRIES];
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [OCC_W-1:0]   occupancy_q;

    logic               lk_hit;
    logic [IDX_W-1:0]   lk_idx;
    logic               up_hit;
    logic [IDX_W-1:0]   up_idx;
    logic               any_free;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   target_idx;
    logic               do_upd;
    logic               alloc_en;
    logic               train_en;

    function automatic logic [OCC_W-1:0] count_valid(input logic [ENTRIES-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            n = n + OCC_W'(v[i]);
        end
        return n;
    endfunction

    // Lookup match; scanning downwards leaves the lowest matching index.
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == bus.lookup_pc) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
        end
    end

    assign bus.pred_hit   = lk_hit;
    assign bus.prediction = (lk_hit && ctr[lk_idx][CTR_W-1]) ? take : no_take;
    assign bus.occupancy  = occupancy_q;

    // Training match and lowest-index free slot search.
    always_comb begin
        up_hit   = 1'b0;
        up_idx   = '0;
        any_free = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == bus.upd_pc) begin
                up_hit = 1'b1;
                up_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Invalidate swallows any concurrent update.
    always_comb begin
        do_upd     = bus.upd_valid && !bus.invalidate;
        alloc_en   = do_upd && !up_hit;
        train_en   = do_upd && up_hit;
        target_idx = any_free ? free_idx : rr_ptr_q;
        valid_d    = valid_q;
        if (alloc_en) begin
            valid_d[target_idx] = 1'b1;
        end
    end

    // Valid bits, replacement pointer and occupancy; pointer only moves when a live entry is evicted.
    always_ff @(posedge clk) begin
        if (reset || bus.invalidate) begin
            valid_q     <= '0;
            rr_ptr_q    <= '0;
            occupancy_q <= '0;
        end else begin
            valid_q     <= valid_d;
            occupancy_q <= count_valid(valid_d);
            if (alloc_en && !any_free) begin
                rr_ptr_q <= rr_ptr_q + IDX_W'(1);
            end
        end
    end

    // Tags are only meaningful under a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (!reset && alloc_en) begin
            tag_q[target_idx] <= bus.upd_pc;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        sat_counter #(.CTR_W(CTR_W)) u_ctr (
            .clk      (clk),
            .reset    (reset),
            .init     (alloc_en && target_idx == IDX_W'(g)),
            .init_val (bus.upd_taken ? WT : WNT),
            .inc_en   (train_en && up_idx == IDX_W'(g)),
            .dir      (bus.upd_taken),
            .ctr      (ctr[g])
        );
    end
endmodule

// File: doc/local_bht_predictor.md
Name: local_bht_predictor

Overview:
Parametrised, fully associative local branch history table for the fetch stage of the pipelined RV32I core.
- Lookup side: fetch PC is matched combinationally; the per-entry saturating counter supplies a take/no_take prediction.
- Update side: a separate resolved-branch port (PC + outcome) trains the counters.
- Misses allocate an entry via a round-robin replacement pointer.
- Supports configurable depth and counter width, explicit valid bits, and a whole-table invalidate.

Parameters:
ENTRIES, 4, number of table entries; power of two, ≥2
CTR_W, 2, saturating counter width in bits; ≥1
PC_W, 32, width of stored/compared PC

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; clock clk
lookup_pc  in  PC_W  fetch-stage PC to predict
prediction  out  prediction_choice  take/no_take for lookup_pc
pred_hit  out  1  lookup_pc matches a valid entry
upd_valid  in  1  resolved branch present this cycle; qualified by pipeline enable upstream
upd_pc  in  PC_W  PC of resolved branch
upd_taken  in  1  actual outcome (1 = taken)
invalidate  in  1  clear all valid bits next edge
occupancy  out  $clog2(ENTRIES)+1  count of valid entries

Behaviour:
- State per entry: valid, tag[PC_W], ctr[CTR_W]. Global: rr_ptr[$clog2(ENTRIES)].
- Reset (sync):
  - all valid=0; all ctr=WNT (2^(CTR_W-1)-1); rr_ptr=0; occupancy=0.
  - Outputs after reset: prediction=no_take, pred_hit=0.
- Lookup (combinational, 0 latency):
  - hit when valid[i] && tag[i]==lookup_pc.
  - On hit: prediction = take iff ctr[i] MSB=1.
  - On miss: prediction=no_take, pred_hit=0.
  - Multiple matches cannot occur by construction; if one does, lowest index wins.
- Update (takes effect at the next clk edge, only when upd_valid=1):
  - Update hit (valid tag match on upd_pc):
    - ctr+1 if upd_taken, saturating at 2^CTR_W-1.
    - ctr-1 if not taken, saturating at 0.
    - rr_ptr unchanged.
  - Update miss:
    - Target index: write at the lowest-index invalid entry if one exists; else at rr_ptr.
    - On the target entry: valid=1, tag=upd_pc, ctr=WT (2^(CTR_W-1)) if upd_taken else WNT.
    - rr_ptr advances (wraps modulo ENTRIES) only when a valid entry is replaced.
  - upd_valid=0: no state change.
- Lookup/update ordering: lookup always sees pre-edge state; no bypass. Same PC in the same cycle predicts from the old counter.
- invalidate:
  - Next edge: all valid=0, rr_ptr=0; counters untouched.
  - Dominates a simultaneous update; that update is dropped.
- Precedence: reset > invalidate > update.
- occupancy: registered count of valid bits; saturates at ENTRIES naturally.
- CTR_W=1: WNT=0, WT=1; the counter degenerates to last-outcome.
- Reset mid-operation: the full table clears on that edge, regardless of upd_valid.

Decomposition:
- rv32i_types (shared package): prediction_choice enum (no_take, take), already shared.
- Local constants: WNT/WT are computed in-module from CTR_W and do not belong in the package.
- Sub-module sat_counter #(CTR_W):
  - Ports: clk, reset, init, init_val, inc_en, dir.
  - Output: ctr.
  - Instantiated ENTRIES times via generate.
- Parent module holds tag/valid arrays, match logic, allocation priority encoder, and rr_ptr.

Test Plan:
1. Reset, lookup_pc=0x40 -> prediction=no_take, pred_hit=0, occupancy=0.
2. upd_valid, upd_pc=0x40, taken=1; next cycle lookup 0x40 -> pred_hit=1, ctr=2, prediction=take; occupancy=1.
3. Training on 0x40 (CTR_W=2):
   - Update 0x40 not-taken twice -> ctr 2→1→0, prediction=no_take.
   - Two more not-taken -> ctr stays 0.
   - Four taken -> ctr 1,2,3,3, prediction=take.
4. Replacement (ENTRIES=4):
   - Allocate 0x100, 0x104, 0x108, 0x10C -> occupancy=4, rr_ptr=0.
   - Allocate 0x110 -> replaces entry0; lookup 0x100 -> miss, 0x110 -> hit; rr_ptr=1.
5. Same-cycle collision: lookup_pc=upd_pc=0x104 with ctr=1, upd_taken=1 -> same-cycle prediction=no_take; next cycle prediction=take.
6. invalidate=1 together with upd_valid (0x200) -> next cycle all lookups miss, occupancy=0; 0x200 not allocated.
